// File: rtl/fifo_rdselector.sv
// Drains per-channel FIFOs round-robin into one channel-tagged valid/ready output stream.
// Latency: rd_en one cycle after a channel becomes eligible; o_valid L+1 cycles after rd_en (FIFO latency L).
// Backpressure: a held word stays on the outputs until i_ready; no new FIFO read is issued meanwhile.
module fifo_rdselector #(
    parameter int CHANNEL_WIDTH  = 32,
    parameter int CHANNELS_CNT   = 3,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int CH_W = $clog2(CHANNELS_CNT),
    localparam int TC_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                                    clk,
    input  logic                                    rst_all_n,
    input  logic [CHANNELS_CNT-1:0]                 i_enable_channels,
    input  logic [CHANNELS_CNT-1:0]                 i_empty_channels,
    output logic [CHANNELS_CNT-1:0]                 o_rd_en_channels,
    input  logic [CHANNELS_CNT-1:0]                 i_rd_valid_channels,
    input  logic [CHANNELS_CNT*CHANNEL_WIDTH-1:0]   i_rd_data_channels,
    output logic                                    o_valid,
    input  logic                                    i_ready,
    output logic [CHANNEL_WIDTH-1:0]                o_data,
    output logic [CH_W-1:0]                         o_channel,
    output logic                                    o_busy,
    output logic                                    o_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                    state, state_nxt;
    logic [CH_W-1:0]           last_grant, last_grant_nxt;
    logic [TC_W-1:0]           tcnt, tcnt_nxt;
    logic [CHANNELS_CNT-1:0]   eligible;
    logic [CHANNELS_CNT-1:0]   rd_en_nxt;
    logic [CH_W-1:0]           grant;
    logic [CH_W-1:0]           idx;
    logic                      valid_nxt;
    logic [CHANNEL_WIDTH-1:0]  data_nxt;
    logic [CH_W-1:0]           channel_nxt;
    logic                      busy_nxt;
    logic                      timeout_nxt;
    logic [CHANNEL_WIDTH-1:0]  rd_data_arr [CHANNELS_CNT];

    for (genvar c = 0; c < CHANNELS_CNT; c++) begin : g_unpack
        assign rd_data_arr[c] = i_rd_data_channels[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end

    assign eligible = i_enable_channels & ~i_empty_channels;

    // Scan downward so the last hit is the nearest eligible channel after last_grant.
    always_comb begin
        grant = last_grant;
        idx   = '0;
        for (int i = CHANNELS_CNT; i >= 1; i--) begin
            idx = CH_W'((int'(last_grant) + i) % CHANNELS_CNT);
            if (eligible[idx]) begin
                grant = idx;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        tcnt_nxt       = tcnt;
        rd_en_nxt      = '0;
        valid_nxt      = o_valid;
        data_nxt       = o_data;
        channel_nxt    = o_channel;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    rd_en_nxt      = CHANNELS_CNT'(1) << grant;
                    last_grant_nxt = grant;
                    tcnt_nxt       = '0;
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                if (i_rd_valid_channels[last_grant]) begin
                    data_nxt    = rd_data_arr[last_grant];
                    channel_nxt = last_grant;
                    valid_nxt   = 1'b1;
                    state_nxt   = HOLD;
                end else if (tcnt == TC_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            state            <= IDLE;
            last_grant       <= CH_W'(CHANNELS_CNT - 1);
            tcnt             <= '0;
            o_rd_en_channels <= '0;
            o_valid          <= 1'b0;
            o_data           <= '0;
            o_channel        <= '0;
            o_busy           <= 1'b0;
            o_timeout        <= 1'b0;
        end else begin
            state            <= state_nxt;
            last_grant       <= last_grant_nxt;
            tcnt             <= tcnt_nxt;
            o_rd_en_channels <= rd_en_nxt;
            o_valid          <= valid_nxt;
            o_data           <= data_nxt;
            o_channel        <= channel_nxt;
            o_busy           <= busy_nxt;
            o_timeout        <= timeout_nxt;
        end
    end

endmodule
